// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP argmax driver.
package mlp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    localparam int unsigned DefNClasses = 10;
    localparam int unsigned DefW        = 16;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select for a running argmax.
// Tie rule: ARGMAX_TIE_LAST_EN defined -> later index wins ties; undefined -> earlier index kept.
module argmax_cmp #(
    parameter int unsigned W    = 16,
    parameter int unsigned IdxW = 4
) (
    input  logic                first,
    input  logic signed [W-1:0] cand,
    input  logic [IdxW-1:0]     cand_idx,
    input  logic signed [W-1:0] cur_max,
    input  logic [IdxW-1:0]     cur_idx,
    output logic signed [W-1:0] sel_max,
    output logic [IdxW-1:0]     sel_idx
);

    logic take;

`ifdef ARGMAX_TIE_LAST_EN
    assign take = first || (cand >= cur_max);
`else
    assign take = first || (cand > cur_max);
`endif

    assign sel_max = take ? cand : cur_max;
    assign sel_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/mlp_argmax_driver.sv
// Collects one frame of output-layer scores and reports the maximum and its class index.
// Optional ARGMAX_TIE_LAST_EN (see argmax_cmp) resolves ties to the highest index.
module mlp_argmax_driver
    import mlp_pkg::*;
#(
    parameter int unsigned N_CLASSES = DefNClasses,
    parameter int unsigned W         = DefW,
    localparam int unsigned IdxW     = $clog2(N_CLASSES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] result,
    output logic [IdxW-1:0]     index
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CLASSES - 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    logic signed [W-1:0] max_q, max_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic signed [W-1:0] result_q, result_d;
    logic [IdxW-1:0]     index_q, index_d;

    logic signed [W-1:0] sel_max;
    logic [IdxW-1:0]     sel_idx;

    // The sample counter doubles as the class index of the incoming score.
    argmax_cmp #(
        .W    (W),
        .IdxW (IdxW)
    ) u_cmp (
        .first    (cnt_q == '0),
        .cand     (in_data),
        .cand_idx (cnt_q),
        .cur_max  (max_q),
        .cur_idx  (idx_q),
        .sel_max  (sel_max),
        .sel_idx  (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            index_q  <= index_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        idx_d    = idx_q;
        result_d = result_q;
        index_d  = index_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                // A start here aborts the frame; in_valid alongside it is dropped.
                if (start) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    max_d = sel_max;
                    idx_d = sel_idx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        result_d = sel_max;
                        index_d  = sel_idx;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q == StCollect);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign index  = index_q;

endmodule

// File: tb/tb_mlp_argmax_driver.sv
// Self-checking bench for mlp_argmax_driver: directed corner frames plus randomized frames.
module tb_mlp_argmax_driver;

    localparam int unsigned N    = 10;
    localparam int unsigned W    = 16;
    localparam int unsigned IdxW = $clog2(N);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                in_valid;
    logic signed [W-1:0] in_data;
    logic                busy;
    logic                done;
    logic signed [W-1:0] result;
    logic [IdxW-1:0]     index;

    int checks   = 0;
    int failures = 0;

    logic signed [W-1:0] frame [N];
    logic signed [W-1:0] last_result;
    logic [IdxW-1:0]     last_index;

    mlp_argmax_driver #(
        .N_CLASSES (N),
        .W         (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .index    (index)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: maximum value of the frame, then the first (or last) class holding it.
    function automatic logic signed [W-1:0] model_max();
        int m = frame[0];
        for (int i = 1; i < N; i++) if (int'(frame[i]) > m) m = frame[i];
        return W'(m);
    endfunction

    function automatic logic [IdxW-1:0] model_idx();
        logic signed [W-1:0] m = model_max();
        int pick = -1;
        for (int i = 0; i < N; i++) begin
            if (frame[i] == m) begin
`ifdef ARGMAX_TIE_LAST_EN
                pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        return IdxW'(pick);
    endfunction

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'(($urandom % 2));
        in_data  = W'($urandom);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_done_low", 32'(done), 32'(0));
        check("start_busy", 32'(busy), 32'(1));
        check("start_result_held", 32'(result), 32'(last_result));
    endtask

    task automatic feed(input logic signed [W-1:0] v, input bit gaps);
        if (gaps) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        logic signed [W-1:0] em;
        logic [IdxW-1:0]     ei;
        em = model_max();
        ei = model_idx();
        pulse_start();
        for (int i = 0; i < N; i++) begin
            feed(frame[i], gaps);
            if (i < N - 1) begin
                check({tag, "_mid_done"}, 32'(done), 32'(0));
                check({tag, "_mid_result_held"}, 32'(result), 32'(last_result));
            end
        end
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_result"}, 32'(result), 32'(em));
        check({tag, "_index"}, 32'(index), 32'(ei));
        last_result = em;
        last_index  = ei;
        // Stray samples after completion must not disturb the held result.
        in_valid = 1'b1;
        in_data  = W'($urandom);
        tick();
        tick();
        in_valid = 1'b0;
        check({tag, "_hold_done"}, 32'(done), 32'(1));
        check({tag, "_hold_result"}, 32'(result), 32'(em));
        check({tag, "_hold_index"}, 32'(index), 32'(ei));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        in_valid    = 1'b1;
        in_data     = 16'sh1234;
        last_result = '0;
        last_index  = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        check("reset_index", 32'(index), 32'(0));
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'(0));

        // Documented example frame.
        frame = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0,
                  16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd8};
        run_frame("example", 1'b0);
        check("example_const_result", 32'(result), 32'(16'sd12));
        check("example_const_index", 32'(index), 32'(2));

        // All equal negative scores.
        for (int i = 0; i < N; i++) frame[i] = 16'shFF9C;
        run_frame("ties", 1'b0);
`ifdef ARGMAX_TIE_LAST_EN
        check("ties_const_index", 32'(index), 32'(9));
`else
        check("ties_const_index", 32'(index), 32'(0));
`endif

        // Signed extremes.
        for (int i = 0; i < N; i++) frame[i] = W'($urandom_range(0, 2000)) - 16'sd1000;
        frame[0] = 16'sh8000;
        frame[9] = 16'sh7FFF;
        run_frame("extreme", 1'b1);
        check("extreme_const_index", 32'(index), 32'(9));

        // Abort after four samples of a frame holding a big value.
        pulse_start();
        for (int i = 0; i < 4; i++) feed(16'sh7000, 1'b0);
        check("abort_mid_done", 32'(done), 32'(0));
        for (int i = 0; i < N; i++) frame[i] = W'($urandom_range(0, 100));
        run_frame("restart", 1'b1);

        // Reset mid-frame, then samples without a start.
        pulse_start();
        for (int i = 0; i < 6; i++) feed(W'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) feed(16'sh0100, 1'b0);
        tick();
        check("rst_mid_done", 32'(done), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_result", 32'(result), 32'(0));
        check("rst_mid_index", 32'(index), 32'(0));
        last_result = '0;
        last_index  = '0;

        // Randomized frames with varied value distributions.
        for (int f = 0; f < 20; f++) begin
            int mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                unique case (mode)
                    0: frame[i] = W'($urandom);
                    1: frame[i] = W'($urandom_range(0, 3)) - 16'sd1;
                    default: begin
                        unique case ($urandom_range(0, 3))
                            0: frame[i] = 16'sh8000;
                            1: frame[i] = 16'sh7FFF;
                            2: frame[i] = 16'sh0000;
                            default: frame[i] = 16'shFFFF;
                        endcase
                    end
                endcase
            end
            run_frame("rand", 1'(f % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
